// File: rtl/xor_parity_engine_pkg.sv
// Shared encodings for the XOR parity engine: mode values and accumulator state.
package xor_parity_pkg;

    localparam logic MODE_WORD  = 1'b0;
    localparam logic MODE_FRAME = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

endpackage

// File: rtl/xor_parity_engine_if.sv
// Word-in / result-out bundle of the XOR parity engine, plus accumulator state for observation.
interface xor_parity_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import xor_parity_pkg::*;

    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;
    logic             frame_err;
    state_t           dbg_state;

    // Both sides transfer on a cycle where valid && ready; valid never waits on ready,
    // and the payload must stay stable while valid is high and ready is low.
    modport master (
        output mode, in_valid, in_data, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_count, frame_err, dbg_state
    );

    modport slave (
        input  mode, in_valid, in_data, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_count, frame_err, dbg_state
    );

endinterface

// File: rtl/xor_parity_engine_xor_reduce.sv
// Combinational WIDTH-to-1 XOR reduction; synthesis balances it into a tree.
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/xor_parity_engine.sv
// Pipelined XOR engine: per-word parity (mode 0) or framed XOR checksum with beat count (mode 1).
module xor_parity_engine
    import xor_parity_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    xor_parity_engine_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             restart;
    logic [WIDTH-1:0] nxt;
    logic [CNT_W-1:0] cnt_n;
    logic [WIDTH-1:0] res_data;
    logic             res_par;

    // Single output register, no skid: a new word is taken only if the slot is free or draining.
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.dbg_state = state;

    // A beat arriving with no frame open is an implicit first beat.
    assign restart  = bus.in_first || (state == IDLE);
    assign nxt      = restart ? bus.in_data : (acc ^ bus.in_data);
    assign cnt_n    = restart ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
    assign res_data = (bus.mode == MODE_WORD) ? bus.in_data : nxt;

    xor_reduce #(.WIDTH(WIDTH)) u_parity (
        .data   (res_data),
        .parity (res_par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_parity <= 1'b0;
            bus.out_count  <= '0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (accept) begin
                if (bus.mode == MODE_WORD) begin
                    // Word mode leaves any open frame untouched.
                    bus.out_valid  <= 1'b1;
                    bus.out_data   <= res_data;
                    bus.out_parity <= res_par ^ ODD_PARITY;
                    bus.out_count  <= CNT_W'(1);
                end else begin
                    bus.frame_err <= bus.in_first && (state == FRAME);
                    if (bus.in_last) begin
                        bus.out_valid  <= 1'b1;
                        bus.out_data   <= res_data;
                        bus.out_parity <= res_par ^ ODD_PARITY;
                        bus.out_count  <= cnt_n;
                        acc            <= '0;
                        cnt            <= '0;
                        state          <= IDLE;
                    end else begin
                        acc   <= nxt;
                        cnt   <= cnt_n;
                        state <= FRAME;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_parity_engine.sv
// Directed and random bench for xor_parity_engine against a frame-level reference model.
module tb_xor_parity_engine;
    import xor_parity_pkg::*;

    localparam int W       = 8;
    localparam int C       = 8;
    localparam bit ODD     = 1'b0;
    localparam int CNT_MAX = (1 << C) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xor_parity_engine_if #(.WIDTH(W), .CNT_W(C)) bus ();

    xor_parity_engine #(.WIDTH(W), .CNT_W(C), .ODD_PARITY(ODD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [C-1:0] cnt_q[$];
    logic [W-1:0] frame_q[$];
    bit           frame_open;
    bit           exp_ferr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_par(input logic [W-1:0] x);
        return bit'($countones(x) % 2) ^ ODD;
    endfunction

    // Frame-level model: keeps the open frame's words and folds them on the last beat.
    task automatic model(input bit m, input logic [W-1:0] d, input bit f, input bit l);
        logic [W-1:0] x;
        int n;
        exp_ferr = 1'b0;
        if (!m) begin
            exp_q.push_back(d);
            cnt_q.push_back(C'(1));
        end else begin
            exp_ferr = f && frame_open;
            if (f || !frame_open) frame_q.delete();
            frame_q.push_back(d);
            frame_open = 1'b1;
            if (l) begin
                x = '0;
                foreach (frame_q[i]) x = x ^ frame_q[i];
                n = frame_q.size();
                exp_q.push_back(x);
                cnt_q.push_back(C'((n > CNT_MAX) ? CNT_MAX : n));
                frame_q.delete();
                frame_open = 1'b0;
            end
        end
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] d;
        logic [C-1:0] c;
        if (exp_q.size() > 0) begin
            d = exp_q.pop_front();
            c = cnt_q.pop_front();
            check({tag, ".valid"},  32'(bus.out_valid),  32'(1));
            check({tag, ".data"},   32'(bus.out_data),   32'(d));
            check({tag, ".parity"}, 32'(bus.out_parity), 32'(ref_par(d)));
            check({tag, ".count"},  32'(bus.out_count),  32'(c));
        end else begin
            check({tag, ".valid"}, 32'(bus.out_valid), 32'(0));
        end
    endtask

    // Called at a negedge with out_ready=1; the beat is accepted on the following posedge.
    task automatic beat(input string tag, input bit m, input logic [W-1:0] d, input bit f, input bit l);
        bus.mode     = m;
        bus.in_data  = d;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        model(m, d, f, l);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".ferr"},  32'(bus.frame_err), 32'(exp_ferr));
        check({tag, ".state"}, 32'(bus.dbg_state == FRAME), 32'(frame_open));
        check_out(tag);
    endtask

    initial begin
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        frame_open    = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("rst.valid",  32'(bus.out_valid),  32'(0));
        check("rst.data",   32'(bus.out_data),   32'(0));
        check("rst.parity", 32'(bus.out_parity), 32'(0));
        check("rst.count",  32'(bus.out_count),  32'(0));
        check("rst.ferr",   32'(bus.frame_err),  32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 32'(1));
        @(negedge clk);

        // Word mode
        beat("w_a5", 1'b0, 8'hA5, 1'b0, 1'b0);

        // Three-beat frame: results only on the last beat
        beat("f3_b0", 1'b1, 8'h0F, 1'b1, 1'b0);
        beat("f3_b1", 1'b1, 8'hF0, 1'b0, 1'b0);
        beat("f3_b2", 1'b1, 8'h3C, 1'b0, 1'b1);

        // Single-word frame
        beat("f1", 1'b1, 8'h01, 1'b1, 1'b1);

        // Back-pressure: result held, pending beat not taken
        beat("bp_w", 1'b0, 8'h5A, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        bus.mode      = 1'b0;
        bus.in_data   = 8'h3C;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.in_ready", 32'(bus.in_ready),   32'(0));
            check("bp.valid",    32'(bus.out_valid),  32'(1));
            check("bp.data",     32'(bus.out_data),   32'(8'h5A));
            check("bp.parity",   32'(bus.out_parity), 32'(ref_par(8'h5A)));
            check("bp.count",    32'(bus.out_count),  32'(1));
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(bus.in_ready), 32'(1));
        model(1'b0, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_out("bp_next");

        // Restart inside an open frame
        beat("fe_b0", 1'b1, 8'h11, 1'b1, 1'b0);
        beat("fe_b1", 1'b1, 8'h22, 1'b1, 1'b1);
        beat("fe_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Word beat interleaved into an open frame
        beat("mx_b0", 1'b1, 8'h12, 1'b1, 1'b0);
        beat("mx_w",  1'b0, 8'h34, 1'b0, 1'b0);
        beat("mx_b1", 1'b1, 8'h56, 1'b0, 1'b1);

        // Implicit first beat while idle
        beat("imp_b0", 1'b1, 8'h81, 1'b0, 1'b0);
        beat("imp_b1", 1'b1, 8'h18, 1'b0, 1'b1);

        // Reset in the middle of a frame
        beat("rf_b0", 1'b1, 8'h55, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        frame_q.delete();
        frame_open = 1'b0;
        check("rf.valid", 32'(bus.out_valid), 32'(0));
        check("rf.data",  32'(bus.out_data),  32'(0));
        check("rf.count", 32'(bus.out_count), 32'(0));
        check("rf.state", 32'(bus.dbg_state == FRAME), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rf.in_ready", 32'(bus.in_ready), 32'(1));
        @(negedge clk);
        beat("rf_b1", 1'b1, 8'h0A, 1'b1, 1'b1);

        // Beat counter saturation over a long frame
        beat("sat_first", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int i = 0; i < 258; i++) begin
            beat("sat_mid", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end
        beat("sat_last", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);

        // Random mix of modes and framing
        for (int i = 0; i < 300; i++) begin
            beat("rnd", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_parity_engine.md
Name: xor_parity_engine

Overview:
Parametrised, pipelined successor to the two-input XOR cell. Takes WIDTH-bit words over a valid/ready handshake and operates in one of two modes:
- Mode 0: per-word XOR reduction (parity of each word).
- Mode 1: bitwise XOR checksum accumulated across a framed burst, with a beat counter and a frame-error flag.
Sits between a word source and a checker or transmitter in the datapath test chips.

Parameters:
WIDTH, 8, data word width in bits (>=2)
CNT_W, 8, width of the frame beat counter (saturating)
ODD_PARITY, 0, 0 = out_parity is even parity (plain XOR reduction); 1 = result inverted

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = per-word parity, 1 = frame checksum; sampled on each accepted beat
in_valid  input  1  source has a word
in_ready  output  1  engine accepts a word this cycle
in_data  input  WIDTH  input word
in_first  input  1  first beat of frame (mode 1 only)
in_last  input  1  last beat of frame (mode 1 only)
out_valid  output  1  result available
out_ready  input  1  sink takes the result
out_data  output  WIDTH  word (mode 0) or XOR checksum of the frame (mode 1)
out_parity  output  1  XOR-reduction of out_data, XOR ODD_PARITY
out_count  output  CNT_W  beats in the frame (1 in mode 0), saturates at all-ones
frame_err  output  1  one-cycle pulse: in_first accepted while a frame is open

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, out_data, out_parity, out_count, frame_err, the accumulator, the beat counter and the in_frame flag all clear to 0. in_ready is 1 as soon as reset deasserts.
- Acceptance: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational, single output register, no skid).
- Output hold: while out_valid && !out_ready, out_data, out_parity and out_count stay stable. out_valid drops on the cycle after a handshake unless a new result loads in the same cycle.
- Latency: result is registered, so out_valid rises 1 cycle after the accepting edge (mode 0), or 1 cycle after the last-beat accept (mode 1).
- Mode 0, per accepted beat:
  - out_data <= in_data; out_parity <= ^in_data ^ ODD_PARITY; out_count <= 1.
  - in_first and in_last are ignored; accumulator and in_frame are untouched.
- Mode 1, accumulator state machine, states IDLE (in_frame=0) and FRAME (in_frame=1). Let nxt = (in_first || !in_frame) ? in_data : acc ^ in_data, and cnt_n = (in_first || !in_frame) ? 1 : sat(cnt+1).
  - Beat not last: acc <= nxt; cnt <= cnt_n; go to FRAME; no output.
  - Beat last: out_data <= nxt; out_parity <= ^nxt ^ ODD_PARITY; out_count <= cnt_n; out_valid <= 1; acc, cnt <= 0; go to IDLE.
  - in_first && in_last on the same beat: single-word frame, count 1.
  - Beat without in_first while IDLE: treated as an implicit first.
  - in_first while in FRAME: frame_err pulses high for 1 cycle; the frame restarts from in_data.
- Counter saturates at 2^CNT_W-1; no wrap.
- Mode change while in FRAME: a mode-0 beat passes through untouched; the open frame continues on the next mode-1 beat.
- Reset mid-frame discards the partial frame; no output is produced for it.

Decomposition:
- Package xor_parity_pkg holds:
  - mode encoding constants MODE_WORD = 0 and MODE_FRAME = 1
  - a state enum: IDLE, FRAME
- One natural sub-module: xor_reduce, a parametrised combinational WIDTH-to-1 XOR tree, reused for out_parity.

Test Plan:
All cases use WIDTH=8, ODD_PARITY=0.
- Mode 0, in 0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_parity=0, out_count=1.
- Mode 1, beats 0x0F(first), 0xF0, 0x3C(last) -> out_data=0xC3, out_parity=0, out_count=3; no output before the last beat.
- Mode 1, 0x01 with first and last set -> out_data=0x01, out_parity=1, out_count=1.
- Result pending with out_ready=0 for 3 cycles -> in_ready=0, outputs stable, no beat accepted; out_ready=1 -> handshake, and in_ready=1 in the same cycle.
- Mode 1, 0x11(first) then 0x22(first, last) -> frame_err pulses 1 cycle on the second accept; out_data=0x22, out_count=1.
- Mode 1, 0x55(first), then rst_n low for 1 cycle, then 0x0A(first, last) -> out_data=0x0A, out_parity=0, out_count=1; no output for the aborted frame.
